// File: rtl/rand_req_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : rand_req_ctrl_pkg                                             |
// | Purpose  : Shared types, defaults and request-decode helpers for the     |
// |            random-number request controller.                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package rand_req_ctrl_pkg;

   // Default fetch timeout handed to the controller by its parent.
   localparam int RCTL_TIMEOUT_CYCLES = 1024;
   // Number of source-word bits that are ever serialized.
   localparam int RCTL_DATA_W         = 64;

   // CPU request encoding; 3'd3 and 3'd7 are illegal.
   typedef enum logic [2:0] {
      RDSEED_16 = 3'd0,
      RDSEED_32 = 3'd1,
      RDSEED_64 = 3'd2,
      RDRAND_16 = 3'd4,
      RDRAND_32 = 3'd5,
      RDRAND_64 = 3'd6
   } rand_req_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2
   } rctl_state_t;

   // Bytes to emit for a request type; 0 flags an illegal encoding.
   function automatic logic [3:0] req_nbytes(input rand_req_t t);
      logic [3:0] n;
      case (t)
         RDSEED_16, RDRAND_16: n = 4'd2;
         RDSEED_32, RDRAND_32: n = 4'd4;
         RDSEED_64, RDRAND_64: n = 4'd8;
         default:              n = 4'd0;
      endcase
      return n;
   endfunction

   // 1 = conditioned-seed source, 0 = DRBG source.
   function automatic logic req_is_seed(input rand_req_t t);
      return (t == RDSEED_16) || (t == RDSEED_32) || (t == RDSEED_64);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rand_byte_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rand_byte_serializer                                          |
// | Purpose  : Shifts a loaded 64-bit word out LSB byte first, one byte per  |
// |            cycle, for the requested number of bytes.                     |
// | Ports    : ic_clk, rst_n   - clock, async active-low reset               |
// |            load            - capture word/nbytes (starts serialization)  |
// |            word, nbytes    - data to send and byte count (2/4/8)         |
// |            done            - current byte is the last one                |
// |            rand_byte       - output byte, valid while rand_valid=1       |
// |            rand_valid      - one byte presented per cycle while high     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rand_byte_serializer
   import rand_req_ctrl_pkg::*;
(
   input  logic                   ic_clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic [RCTL_DATA_W-1:0] word,
   input  logic [3:0]             nbytes,
   output logic                   done,
   output logic [7:0]             rand_byte,
   output logic                   rand_valid
);

   logic [RCTL_DATA_W-1:0] shift_q, shift_d;
   logic [3:0]             cnt_q,   cnt_d;

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (load) begin
         shift_d = word;
         cnt_d   = nbytes;
      end else if (cnt_q == 4'd1) begin
         // Scrub leftover upper bytes so nothing stale lingers on rand_byte.
         shift_d = '0;
         cnt_d   = 4'd0;
      end else if (cnt_q != 4'd0) begin
         shift_d = shift_q >> 8;
         cnt_d   = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge ic_clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= 4'd0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   // Both outputs come straight from flops, so reset clears them at once.
   assign rand_byte  = shift_q[7:0];
   assign rand_valid = (cnt_q != 4'd0);
   assign done       = (cnt_q == 4'd1);

endmodule
`default_nettype wire

// File: rtl/rand_req_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rand_req_ctrl                                                 |
// | Purpose  : Accepts CPU random-number requests, fetches one word from the |
// |            seed or DRBG source, and serializes 2/4/8 bytes to the CPU.   |
// |            Owns source selection, fetch timeout and debug lockout.       |
// | Ports    : ic_clk, rst_n            - clock, async active-low reset      |
// |            debug                    - blocks new requests while high     |
// |            rand_req, rand_req_type  - CPU request level and type         |
// |            rand_byte, rand_valid    - serialized output stream           |
// |            rand_busy, rand_err      - status / error pulse               |
// |            seed_valid/word/ready    - conditioned-seed source handshake  |
// |            drbg_valid/word/ready    - DRBG source handshake              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rand_req_ctrl
   import rand_req_ctrl_pkg::*;
#(
   parameter int WORD_W         = 64,
   parameter int TIMEOUT_CYCLES = RCTL_TIMEOUT_CYCLES
) (
   input  logic              ic_clk,
   input  logic              rst_n,
   input  logic              debug,
   input  logic              rand_req,
   input  rand_req_t         rand_req_type,
   output logic [7:0]        rand_byte,
   output logic              rand_valid,
   output logic              rand_busy,
   output logic              rand_err,
   input  logic              seed_valid,
   input  logic [WORD_W-1:0] seed_word,
   output logic              seed_ready,
   input  logic              drbg_valid,
   input  logic [WORD_W-1:0] drbg_word,
   output logic              drbg_ready
);

   localparam int              TO_W       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   rctl_state_t      state_q,    state_d;
   logic             sel_seed_q, sel_seed_d;
   logic [3:0]       nbytes_q,   nbytes_d;
   logic [TO_W-1:0]  timer_q,    timer_d;
   logic             err_q,      err_d;

   logic                   load;
   logic                   done;
   logic                   src_valid;
   logic [RCTL_DATA_W-1:0] src_word;

   // Source bits above the serialized width are intentionally dropped.
   generate
      if (WORD_W > RCTL_DATA_W) begin : g_wide_word
         logic unused_hi;
         assign unused_hi = ^{seed_word[WORD_W-1:RCTL_DATA_W],
                              drbg_word[WORD_W-1:RCTL_DATA_W]};
      end
   endgenerate

   assign src_valid = sel_seed_q ? seed_valid : drbg_valid;
   assign src_word  = sel_seed_q ? seed_word[RCTL_DATA_W-1:0]
                                 : drbg_word[RCTL_DATA_W-1:0];

   // Only the selected source ever sees ready, and only while fetching.
   assign seed_ready = (state_q == FETCH) &&  sel_seed_q;
   assign drbg_ready = (state_q == FETCH) && !sel_seed_q;

   assign rand_busy = (state_q != IDLE);
   assign rand_err  = err_q;

   always_comb begin
      state_d    = state_q;
      sel_seed_d = sel_seed_q;
      nbytes_d   = nbytes_q;
      timer_d    = timer_q;
      err_d      = 1'b0;
      load       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rand_req && !debug) begin
               if (req_nbytes(rand_req_type) == 4'd0) begin
                  err_d = 1'b1;
               end else begin
                  nbytes_d   = req_nbytes(rand_req_type);
                  sel_seed_d = req_is_seed(rand_req_type);
                  timer_d    = '0;
                  state_d    = FETCH;
               end
            end
         end
         FETCH: begin
            // A handshake on the final allowed cycle still wins over timeout.
            if (src_valid) begin
               load    = 1'b1;
               state_d = SEND;
            end else if (timer_q == TIMER_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TO_W'(1);
            end
         end
         SEND: begin
            if (done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ic_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sel_seed_q <= 1'b0;
         nbytes_q   <= 4'd0;
         timer_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_seed_q <= sel_seed_d;
         nbytes_q   <= nbytes_d;
         timer_q    <= timer_d;
         err_q      <= err_d;
      end
   end

   rand_byte_serializer u_ser (
      .ic_clk     (ic_clk),
      .rst_n      (rst_n),
      .load       (load),
      .word       (src_word),
      .nbytes     (nbytes_q),
      .done       (done),
      .rand_byte  (rand_byte),
      .rand_valid (rand_valid)
   );

endmodule
`default_nettype wire

// File: tb/tb_rand_req_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rand_req_ctrl                                              |
// | Purpose  : Self-checking bench for rand_req_ctrl. A cycle timeline model |
// |            derived from the request rules predicts every output.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_rand_req_ctrl;
   import rand_req_ctrl_pkg::*;

   localparam int TB_TIMEOUT = 16;
   localparam int NEVER      = 1000;
   localparam int MAXC       = 64;

   logic        ic_clk = 1'b0;
   logic        rst_n;
   logic        debug;
   logic        rand_req;
   rand_req_t   rand_req_type;
   logic [7:0]  rand_byte;
   logic        rand_valid, rand_busy, rand_err;
   logic        seed_valid, seed_ready, drbg_valid, drbg_ready;
   logic [63:0] seed_word, drbg_word;

   int checks = 0;
   int errors = 0;

   // Per-cycle observations and predictions (index = cycle after start).
   logic       mon_valid[MAXC], mon_busy[MAXC], mon_err[MAXC], mon_srdy[MAXC], mon_drdy[MAXC];
   logic [7:0] mon_byte[MAXC];
   logic       exp_valid[MAXC], exp_busy[MAXC], exp_err[MAXC], exp_srdy[MAXC], exp_drdy[MAXC];
   logic [7:0] exp_byte[MAXC];

   // Scenario knobs applied by start_run / run_cycles and read by the model.
   logic        init_req, init_debug, init_sv;
   rand_req_t   init_type, switch_type;
   int          drop_at, switch_at, debug_at, sv_at;
   logic [63:0] cur_sw, cur_dw;

   always #5 ic_clk = ~ic_clk;

   rand_req_ctrl #(
      .WORD_W         (64),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .ic_clk        (ic_clk),
      .rst_n         (rst_n),
      .debug         (debug),
      .rand_req      (rand_req),
      .rand_req_type (rand_req_type),
      .rand_byte     (rand_byte),
      .rand_valid    (rand_valid),
      .rand_busy     (rand_busy),
      .rand_err      (rand_err),
      .seed_valid    (seed_valid),
      .seed_word     (seed_word),
      .seed_ready    (seed_ready),
      .drbg_valid    (drbg_valid),
      .drbg_word     (drbg_word),
      .drbg_ready    (drbg_ready)
   );

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   function automatic int model_nbytes(input rand_req_t t);
      case (t)
         RDSEED_16, RDRAND_16: return 2;
         RDSEED_32, RDRAND_32: return 4;
         RDSEED_64, RDRAND_64: return 8;
         default:              return 0;
      endcase
   endfunction

   function automatic logic model_is_seed(input rand_req_t t);
      return (t == RDSEED_16) || (t == RDSEED_32) || (t == RDSEED_64);
   endfunction

   function automatic logic [12:0] obs_vec(input int i);
      return {mon_valid[i], mon_busy[i], mon_err[i], mon_srdy[i], mon_drdy[i],
              mon_valid[i] ? mon_byte[i] : 8'h00};
   endfunction

   function automatic logic [12:0] exp_vec(input int i);
      return {exp_valid[i], exp_busy[i], exp_err[i], exp_srdy[i], exp_drdy[i],
              exp_valid[i] ? exp_byte[i] : 8'h00};
   endfunction

   task automatic clear_exp();
      for (int i = 0; i < MAXC; i++) begin
         exp_valid[i] = 1'b0; exp_busy[i] = 1'b0; exp_err[i] = 1'b0;
         exp_srdy[i]  = 1'b0; exp_drdy[i] = 1'b0; exp_byte[i] = 8'h00;
      end
   endtask

   task automatic reset_hooks();
      init_req    = 1'b1;
      init_debug  = 1'b0;
      init_sv     = 1'b1;
      init_type   = RDSEED_64;
      switch_type = RDSEED_64;
      drop_at     = 1;
      switch_at   = NEVER;
      debug_at    = NEVER;
      sv_at       = NEVER;
   endtask

   // Request timeline: a request seen in an idle cycle c (not debug-locked) is
   // fetched in c+1 and its bytes occupy c+2 .. c+1+n; c+n+2 is idle again.
   // Illegal types only raise err in c+1. Sources are assumed always valid.
   task automatic model_build(input int n);
      int          c, nb;
      rand_req_t   t;
      logic [63:0] w;
      clear_exp();
      c = 0;
      while (c < n) begin
         t = (c >= switch_at) ? switch_type : init_type;
         if (init_req && (c < drop_at) && !(init_debug || (c >= debug_at))) begin
            nb = model_nbytes(t);
            if (nb == 0) begin
               exp_err[c+1] = 1'b1;
               c = c + 1;
            end else begin
               w = model_is_seed(t) ? cur_sw : cur_dw;
               exp_busy[c+1] = 1'b1;
               exp_srdy[c+1] = model_is_seed(t);
               exp_drdy[c+1] = !model_is_seed(t);
               for (int k = 0; k < nb; k++) begin
                  exp_valid[c+2+k] = 1'b1;
                  exp_busy[c+2+k]  = 1'b1;
                  exp_byte[c+2+k]  = w[8*k +: 8];
               end
               c = c + nb + 2;
            end
         end else begin
            c = c + 1;
         end
      end
   endtask

   task automatic idle(input int n);
      rand_req = 1'b0;
      debug    = 1'b0;
      repeat (n) @(negedge ic_clk);
   endtask

   // Must be called at a falling edge; this is cycle 0 of the run.
   task automatic start_run();
      rand_req      = init_req;
      rand_req_type = init_type;
      debug         = init_debug;
      seed_word     = cur_sw;
      drbg_word     = cur_dw;
      seed_valid    = init_sv;
      drbg_valid    = 1'b1;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 1; i <= n; i++) begin
         @(negedge ic_clk);
         mon_valid[i] = rand_valid; mon_busy[i] = rand_busy; mon_err[i] = rand_err;
         mon_srdy[i]  = seed_ready; mon_drdy[i] = drbg_ready; mon_byte[i] = rand_byte;
         if (i == drop_at)   rand_req      = 1'b0;
         if (i == switch_at) rand_req_type = switch_type;
         if (i == debug_at)  debug         = 1'b1;
         if (i == sv_at)     seed_valid    = 1'b1;
      end
   endtask

   task automatic test_reset();
      rand_req   = 1'b1;
      seed_valid = 1'b1;
      drbg_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge ic_clk);
         checks++;
         if ({rand_valid, rand_busy, rand_err, seed_ready, drbg_ready, rand_byte} !== 13'h0) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: got %h expected 0000",
                     i, {rand_valid, rand_busy, rand_err, seed_ready, drbg_ready, rand_byte});
         end
      end
      rand_req = 1'b0;
      rst_n    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge ic_clk);
         checks++;
         if ({rand_valid, rand_busy, rand_err, seed_ready, drbg_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_release cycle %0d: got %b expected 00000",
                     i, {rand_valid, rand_busy, rand_err, seed_ready, drbg_ready});
         end
      end
   endtask

   task automatic test_seed64();
      reset_hooks();
      cur_sw    = 64'h0123_4567_89AB_CDEF;
      cur_dw    = {$urandom(), $urandom()};
      init_type = RDSEED_64;
      start_run();
      run_cycles(12);
      model_build(12);
      for (int i = 1; i <= 12; i++) begin
         checks++;
         if (obs_vec(i) !== exp_vec(i)) begin
            errors++;
            $display("FAIL seed64 cycle %0d: got %h expected %h (valid,busy,err,srdy,drdy,byte)",
                     i, obs_vec(i), exp_vec(i));
         end
      end
      idle(2);
   endtask

   task automatic test_rdrand16();
      reset_hooks();
      cur_sw    = {$urandom(), $urandom()};
      cur_dw    = 64'hFFFF_FFFF_FFFF_BEEF;
      init_type = RDRAND_16;
      start_run();
      run_cycles(7);
      model_build(7);
      for (int i = 1; i <= 7; i++) begin
         checks++;
         if (obs_vec(i) !== exp_vec(i)) begin
            errors++;
            $display("FAIL rdrand16 cycle %0d: got %h expected %h (valid,busy,err,srdy,drdy,byte)",
                     i, obs_vec(i), exp_vec(i));
         end
      end
      idle(2);
   endtask

   task automatic test_illegal();
      for (int j = 0; j < 2; j++) begin
         reset_hooks();
         cur_sw    = {$urandom(), $urandom()};
         cur_dw    = {$urandom(), $urandom()};
         init_type = (j == 0) ? rand_req_t'(3'd3) : rand_req_t'(3'd7);
         start_run();
         run_cycles(5);
         model_build(5);
         for (int i = 1; i <= 5; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
               errors++;
               $display("FAIL illegal%0d cycle %0d: got %h expected %h (valid,busy,err,srdy,drdy,byte)",
                        j, i, obs_vec(i), exp_vec(i));
            end
         end
         idle(2);
      end
   endtask

   // j=0: source never valid; j=1: valid on the last fetch cycle (accepted);
   // j=2: valid one cycle too late (timeout, then no handshake without a request).
   task automatic test_timeout();
      for (int j = 0; j < 3; j++) begin
         reset_hooks();
         cur_sw    = {$urandom(), $urandom()};
         cur_dw    = {$urandom(), $urandom()};
         init_type = RDSEED_32;
         init_sv   = 1'b0;
         sv_at     = (j == 0) ? NEVER : (j == 1) ? TB_TIMEOUT : TB_TIMEOUT + 1;
         start_run();
         run_cycles(26);
         clear_exp();
         for (int i = 1; i <= TB_TIMEOUT; i++) begin
            exp_busy[i] = 1'b1;
            exp_srdy[i] = 1'b1;
         end
         if (j == 1) begin
            for (int k = 0; k < 4; k++) begin
               exp_valid[TB_TIMEOUT+1+k] = 1'b1;
               exp_busy[TB_TIMEOUT+1+k]  = 1'b1;
               exp_byte[TB_TIMEOUT+1+k]  = cur_sw[8*k +: 8];
            end
         end else begin
            exp_err[TB_TIMEOUT+1] = 1'b1;
         end
         for (int i = 1; i <= 26; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
               errors++;
               $display("FAIL timeout%0d cycle %0d: got %h expected %h (valid,busy,err,srdy,drdy,byte)",
                        j, i, obs_vec(i), exp_vec(i));
            end
         end
         idle(2);
      end
   endtask

   task automatic test_back_to_back();
      reset_hooks();
      cur_sw      = {$urandom(), $urandom()};
      cur_dw      = {$urandom(), $urandom()};
      init_type   = RDSEED_32;
      switch_type = RDRAND_64;
      switch_at   = 3;
      drop_at     = 8;
      start_run();
      run_cycles(20);
      model_build(20);
      for (int i = 1; i <= 20; i++) begin
         checks++;
         if (obs_vec(i) !== exp_vec(i)) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: got %h expected %h (valid,busy,err,srdy,drdy,byte)",
                     i, obs_vec(i), exp_vec(i));
         end
      end
      idle(2);
   endtask

   task automatic test_debug();
      // Debug held with a pending request: nothing may start.
      reset_hooks();
      cur_sw     = {$urandom(), $urandom()};
      cur_dw     = {$urandom(), $urandom()};
      init_debug = 1'b1;
      drop_at    = 20;
      start_run();
      run_cycles(22);
      model_build(22);
      for (int i = 1; i <= 22; i++) begin
         checks++;
         if (obs_vec(i) !== exp_vec(i)) begin
            errors++;
            $display("FAIL debug_lock cycle %0d: got %h expected %h (valid,busy,err,srdy,drdy,byte)",
                     i, obs_vec(i), exp_vec(i));
         end
      end
      idle(2);
      // Debug rising mid-send: request completes, then held off in idle.
      reset_hooks();
      cur_sw    = {$urandom(), $urandom()};
      cur_dw    = {$urandom(), $urandom()};
      init_type = RDSEED_64;
      drop_at   = NEVER;
      debug_at  = 3;
      start_run();
      run_cycles(16);
      model_build(16);
      for (int i = 1; i <= 16; i++) begin
         checks++;
         if (obs_vec(i) !== exp_vec(i)) begin
            errors++;
            $display("FAIL debug_midsend cycle %0d: got %h expected %h (valid,busy,err,srdy,drdy,byte)",
                     i, obs_vec(i), exp_vec(i));
         end
      end
      idle(2);
   endtask

   task automatic test_random();
      for (int it = 0; it < 10; it++) begin
         reset_hooks();
         cur_sw    = {$urandom(), $urandom()};
         cur_dw    = {$urandom(), $urandom()};
         init_type = rand_req_t'(3'($urandom_range(0, 7)));
         if ($urandom_range(0, 1) == 1) drop_at = $urandom_range(2, 20);
         if ($urandom_range(0, 1) == 1) begin
            switch_at   = $urandom_range(1, 15);
            switch_type = rand_req_t'(3'($urandom_range(0, 7)));
         end
         start_run();
         run_cycles(32);
         model_build(32);
         for (int i = 1; i <= 32; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
               errors++;
               $display("FAIL random%0d cycle %0d: got %h expected %h (valid,busy,err,srdy,drdy,byte)",
                        it, i, obs_vec(i), exp_vec(i));
            end
         end
         idle(2);
      end
   endtask

   task automatic test_reset_mid();
      reset_hooks();
      cur_sw    = {$urandom(), $urandom()};
      cur_dw    = {$urandom(), $urandom()};
      init_type = RDSEED_64;
      start_run();
      run_cycles(5);
      checks++;
      if ({mon_valid[5], mon_byte[5]} !== {1'b1, cur_sw[31:24]}) begin
         errors++;
         $display("FAIL reset_mid_byte3: got %h expected %h", {mon_valid[5], mon_byte[5]},
                  {1'b1, cur_sw[31:24]});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({rand_valid, rand_busy, rand_err, seed_ready, drbg_ready, rand_byte} !== 13'h0) begin
         errors++;
         $display("FAIL reset_mid_async: got %h expected 0000",
                  {rand_valid, rand_busy, rand_err, seed_ready, drbg_ready, rand_byte});
      end
      rand_req = 1'b0;
      @(negedge ic_clk);
      rst_n = 1'b1;
      @(negedge ic_clk);
      checks++;
      if ({rand_valid, rand_busy, rand_err, seed_ready, drbg_ready} !== 5'b0) begin
         errors++;
         $display("FAIL reset_mid_idle: got %b expected 00000",
                  {rand_valid, rand_busy, rand_err, seed_ready, drbg_ready});
      end
      // Fresh request after reset must carry only the new word.
      reset_hooks();
      cur_sw    = {$urandom(), $urandom()};
      cur_dw    = {$urandom(), $urandom()};
      init_type = RDSEED_64;
      start_run();
      run_cycles(12);
      model_build(12);
      for (int i = 1; i <= 12; i++) begin
         checks++;
         if (obs_vec(i) !== exp_vec(i)) begin
            errors++;
            $display("FAIL reset_mid_fresh cycle %0d: got %h expected %h (valid,busy,err,srdy,drdy,byte)",
                     i, obs_vec(i), exp_vec(i));
         end
      end
      idle(2);
   endtask

   initial begin
      rst_n         = 1'b0;
      debug         = 1'b0;
      rand_req      = 1'b0;
      rand_req_type = RDSEED_16;
      seed_valid    = 1'b0;
      drbg_valid    = 1'b0;
      seed_word     = 64'h0;
      drbg_word     = 64'h0;
      reset_hooks();
      cur_sw        = 64'h0;
      cur_dw        = 64'h0;

      test_reset();
      test_seed64();
      test_rdrand16();
      test_illegal();
      test_timeout();
      test_back_to_back();
      test_debug();
      test_random();
      test_reset_mid();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
